// File: rtl/ccu_txn_arbiter.sv
// Transaction-level round-robin arbiter that shares one CCU FSM between several
// ACE initiating masters, holding each grant until the owner's transaction completes.

package ccu_txn_arbiter_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  id;
    } ace_ax_t;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } ace_w_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } ace_b_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  id;
        logic        last;
    } ace_r_t;

    typedef struct packed {
        ace_ax_t aw;
        logic    aw_valid;
        ace_w_t  w;
        logic    w_valid;
        logic    b_ready;
        ace_ax_t ar;
        logic    ar_valid;
        logic    r_ready;
    } ace_req_t;

    typedef struct packed {
        logic   aw_ready;
        logic   ar_ready;
        logic   w_ready;
        ace_b_t b;
        logic   b_valid;
        ace_r_t r;
        logic   r_valid;
    } ace_resp_t;

endpackage

// Handshake rule on every channel: a beat transfers on a clock edge where valid
// and ready are both high; valid, once raised, is held until that edge.
module ccu_txn_arbiter #(
    parameter int unsigned NoSlvPorts = 4,
    parameter int unsigned IdxWidth   = (NoSlvPorts > 32'd1) ? $clog2(NoSlvPorts) : 32'd1,
    parameter type         slv_req_t  = ccu_txn_arbiter_pkg::ace_req_t,
    parameter type         slv_resp_t = ccu_txn_arbiter_pkg::ace_resp_t
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  slv_req_t            slv_req_i  [NoSlvPorts],
    output slv_resp_t           slv_resp_o [NoSlvPorts],
    output slv_req_t            ccu_req_o,
    input  slv_resp_t           ccu_resp_i,
    output logic                busy_o,
    output logic [IdxWidth-1:0] grant_idx_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [IdxWidth-1:0] rr_ptr_q, rr_ptr_d;
    logic [IdxWidth-1:0] grant_idx_q, grant_idx_d;
    logic                is_read_q, is_read_d;

    logic [IdxWidth-1:0] pick_idx;
    logic [IdxWidth-1:0] cand_idx;
    int unsigned         cand;
    logic                any_req;
    logic                addr_hs;
    logic                txn_done;

    // First requesting port at or after rr_ptr, wrapping around.
    always_comb begin
        any_req  = 1'b0;
        pick_idx = '0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned off = 0; off < NoSlvPorts; off++) begin
            cand     = (32'(rr_ptr_q) + off) % NoSlvPorts;
            cand_idx = IdxWidth'(cand);
            if (!any_req && (slv_req_i[cand_idx].ar_valid || slv_req_i[cand_idx].aw_valid)) begin
                any_req  = 1'b1;
                pick_idx = cand_idx;
            end
        end
    end

    // Owner's channels pass through; the address channel not in use (and both in RESP) is masked.
    always_comb begin
        ccu_req_o = '0;
        for (int unsigned i = 0; i < NoSlvPorts; i++) begin
            slv_resp_o[i] = '0;
        end
        if (state_q != IDLE) begin
            ccu_req_o               = slv_req_i[grant_idx_q];
            slv_resp_o[grant_idx_q] = ccu_resp_i;
            if ((state_q == RESP) || !is_read_q) begin
                ccu_req_o.ar_valid               = 1'b0;
                slv_resp_o[grant_idx_q].ar_ready = 1'b0;
            end
            if ((state_q == RESP) || is_read_q) begin
                ccu_req_o.aw_valid               = 1'b0;
                slv_resp_o[grant_idx_q].aw_ready = 1'b0;
            end
        end
    end

    assign addr_hs  = is_read_q ? (ccu_req_o.ar_valid & ccu_resp_i.ar_ready)
                                : (ccu_req_o.aw_valid & ccu_resp_i.aw_ready);
    assign txn_done = is_read_q ? (ccu_resp_i.r_valid & ccu_req_o.r_ready & ccu_resp_i.r.last)
                                : (ccu_resp_i.b_valid & ccu_req_o.b_ready);

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_idx_d = grant_idx_q;
        is_read_d   = is_read_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_idx_d = pick_idx;
                    is_read_d   = slv_req_i[pick_idx].ar_valid;
                    state_d     = ADDR;
                end
            end
            ADDR: begin
                if (addr_hs) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (txn_done) begin
                    state_d  = IDLE;
                    rr_ptr_d = (grant_idx_q == IdxWidth'(NoSlvPorts - 1)) ? '0 : grant_idx_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_idx_q <= '0;
            is_read_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_idx_q <= grant_idx_d;
            is_read_q   <= is_read_d;
        end
    end

    assign busy_o      = (state_q != IDLE);
    assign grant_idx_o = grant_idx_q;

endmodule

// File: tb/tb_ccu_txn_arbiter.sv
// Directed bench for ccu_txn_arbiter: inputs change 1 time unit after each rising
// edge, outputs are compared 1 time unit later, well before the next edge.
module tb_ccu_txn_arbiter;
    import ccu_txn_arbiter_pkg::*;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    ace_req_t   slv_req  [N];
    ace_resp_t  slv_resp [N];
    ace_req_t   ccu_req;
    ace_resp_t  ccu_resp;
    logic       busy;
    logic [1:0] gidx;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int rr_exp [6] = '{1, 3, 0, 1, 3, 0};

    always #5 clk = ~clk;

    ccu_txn_arbiter #(.NoSlvPorts(N)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .slv_req_i   (slv_req),
        .slv_resp_o  (slv_resp),
        .ccu_req_o   (ccu_req),
        .ccu_resp_i  (ccu_resp),
        .busy_o      (busy),
        .grant_idx_o (gidx)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < N; i++) slv_req[i] = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---------------- reset
        rst_n    = 1'b0;
        clear_reqs();
        ccu_resp = '0;
        ccu_resp.ar_ready = 1'b1;
        tick();
        tick();
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_gidx", 128'(gidx), 128'(0));
        chk("rst_ccu_req", 128'(ccu_req), 128'(0));
        for (int i = 0; i < N; i++) chk("rst_slv_resp", 128'(slv_resp[i]), 128'(0));
        rst_n    = 1'b1;
        ccu_resp = '0;
        tick();

        // ---------------- single read on port 2
        slv_req[2].ar_valid = 1'b1;
        slv_req[2].ar.addr  = 32'h40;
        slv_req[2].r_ready  = 1'b1;
        ccu_resp.ar_ready   = 1'b1;
        ccu_resp.aw_ready   = 1'b1;
        settle();
        chk("idle_no_ready", 128'(slv_resp[2]), 128'(0));
        chk("idle_ccu_req", 128'(ccu_req), 128'(0));
        chk("idle_busy", 128'(busy), 128'(0));
        tick();
        chk("rd_gidx", 128'(gidx), 128'(2));
        chk("rd_busy", 128'(busy), 128'(1));
        chk("rd_ar_valid", 128'(ccu_req.ar_valid), 128'(1));
        chk("rd_ar_addr", 128'(ccu_req.ar.addr), 128'(32'h40));
        chk("rd_aw_masked", 128'(ccu_req.aw_valid), 128'(0));
        chk("rd_ar_ready", 128'(slv_resp[2].ar_ready), 128'(1));
        chk("rd_aw_ready_masked", 128'(slv_resp[2].aw_ready), 128'(0));
        tick();
        ccu_resp.r_valid = 1'b1;
        ccu_resp.r.data  = 32'hAA;
        ccu_resp.r.last  = 1'b0;
        settle();
        chk("resp_ar_valid_masked", 128'(ccu_req.ar_valid), 128'(0));
        chk("resp_ar_ready_masked", 128'(slv_resp[2].ar_ready), 128'(0));
        chk("resp_r_valid", 128'(slv_resp[2].r_valid), 128'(1));
        chk("resp_r_data", 128'(slv_resp[2].r.data), 128'(32'hAA));
        chk("resp_busy", 128'(busy), 128'(1));
        tick();
        ccu_resp.r.last = 1'b1;
        settle();
        chk("resp_nonlast_busy", 128'(busy), 128'(1));
        tick();

        // ---------------- rr_ptr=3: ports 0 and 3 request, 3 wins; isolation of port 0
        slv_req[2] = '0;
        ccu_resp   = '0;
        slv_req[0].ar_valid = 1'b1;
        slv_req[0].r_ready  = 1'b1;
        slv_req[3].ar_valid = 1'b1;
        slv_req[3].r_ready  = 1'b1;
        settle();
        chk("rel_busy", 128'(busy), 128'(0));
        chk("rel_gidx_hold", 128'(gidx), 128'(2));
        tick();
        chk("rr3_gidx", 128'(gidx), 128'(3));
        ccu_resp.ar_ready = 1'b1;
        tick();
        ccu_resp.aw_ready = 1'b1;
        ccu_resp.w_ready  = 1'b1;
        ccu_resp.r_valid  = 1'b1;
        ccu_resp.b_valid  = 1'b1;
        settle();
        chk("iso_slv0", 128'(slv_resp[0]), 128'(0));
        chk("iso_ar_valid", 128'(ccu_req.ar_valid), 128'(0));
        chk("iso_own_ar_ready", 128'(slv_resp[3].ar_ready), 128'(0));
        tick();
        ccu_resp.r.last = 1'b1;
        settle();
        chk("iso_slv0_b", 128'(slv_resp[0]), 128'(0));
        tick();
        slv_req[3] = '0;
        ccu_resp   = '0;
        settle();
        chk("bubble_busy", 128'(busy), 128'(0));
        chk("bubble_slv0", 128'(slv_resp[0]), 128'(0));
        tick();
        chk("wrap_gidx", 128'(gidx), 128'(0));
        ccu_resp.ar_ready = 1'b1;
        tick();
        ccu_resp.ar_ready = 1'b0;
        ccu_resp.r_valid  = 1'b1;
        ccu_resp.r.last   = 1'b1;
        tick();
        clear_reqs();
        ccu_resp = '0;

        // ---------------- round robin over ports 0,1,3 starting at rr_ptr=1
        for (int p = 0; p < N; p++) begin
            if (p != 2) begin
                slv_req[p].ar_valid = 1'b1;
                slv_req[p].r_ready  = 1'b1;
            end
        end
        for (int k = 0; k < 6; k++) begin
            settle();
            chk("rr_bubble", 128'(busy), 128'(0));
            tick();
            chk("rr_gidx", 128'(gidx), 128'(rr_exp[k]));
            chk("rr_busy", 128'(busy), 128'(1));
            ccu_resp.ar_ready = 1'b1;
            tick();
            ccu_resp.ar_ready = 1'b0;
            ccu_resp.r_valid  = 1'b1;
            ccu_resp.r.last   = 1'b1;
            tick();
            ccu_resp = '0;
        end
        clear_reqs();

        // ---------------- same-port AR+AW on port 1 (rr_ptr=1)
        slv_req[1].ar_valid = 1'b1;
        slv_req[1].aw_valid = 1'b1;
        slv_req[1].aw.addr  = 32'h80;
        slv_req[1].w_valid  = 1'b1;
        slv_req[1].w.data   = 32'h55;
        slv_req[1].w.last   = 1'b1;
        slv_req[1].b_ready  = 1'b1;
        slv_req[1].r_ready  = 1'b1;
        tick();
        ccu_resp.ar_ready = 1'b1;
        ccu_resp.aw_ready = 1'b1;
        settle();
        chk("ab_gidx", 128'(gidx), 128'(1));
        chk("ab_ar_valid", 128'(ccu_req.ar_valid), 128'(1));
        chk("ab_aw_masked", 128'(ccu_req.aw_valid), 128'(0));
        chk("ab_aw_ready_masked", 128'(slv_resp[1].aw_ready), 128'(0));
        chk("ab_ar_ready", 128'(slv_resp[1].ar_ready), 128'(1));
        tick();
        slv_req[1].ar_valid = 1'b0;
        ccu_resp.ar_ready   = 1'b0;
        ccu_resp.r_valid    = 1'b1;
        ccu_resp.r.last     = 1'b1;
        settle();
        chk("ab_resp_aw_ready", 128'(slv_resp[1].aw_ready), 128'(0));
        chk("ab_resp_aw_valid", 128'(ccu_req.aw_valid), 128'(0));
        tick();
        ccu_resp = '0;
        settle();
        chk("ab_bubble", 128'(busy), 128'(0));
        tick();
        chk("ab_wr_gidx", 128'(gidx), 128'(1));
        chk("ab_wr_aw_valid", 128'(ccu_req.aw_valid), 128'(1));
        chk("ab_wr_ar_masked", 128'(ccu_req.ar_valid), 128'(0));
        chk("ab_wr_aw_addr", 128'(ccu_req.aw.addr), 128'(32'h80));
        ccu_resp.aw_ready = 1'b1;
        ccu_resp.ar_ready = 1'b1;
        ccu_resp.w_ready  = 1'b1;
        settle();
        chk("ab_wr_aw_ready", 128'(slv_resp[1].aw_ready), 128'(1));
        chk("ab_wr_ar_ready_masked", 128'(slv_resp[1].ar_ready), 128'(0));
        chk("ab_wr_w_ready", 128'(slv_resp[1].w_ready), 128'(1));
        tick();
        slv_req[1].aw_valid = 1'b0;
        slv_req[1].w_valid  = 1'b0;
        ccu_resp = '0;
        ccu_resp.b_valid = 1'b1;
        settle();
        chk("ab_b_valid", 128'(slv_resp[1].b_valid), 128'(1));
        chk("ab_b_busy", 128'(busy), 128'(1));
        tick();
        ccu_resp   = '0;
        slv_req[1] = '0;
        settle();
        chk("ab_release", 128'(busy), 128'(0));

        // ---------------- write with early W on port 0 (rr_ptr=2)
        slv_req[0].w_valid = 1'b1;
        slv_req[0].w.data  = 32'h1234;
        slv_req[0].w.last  = 1'b1;
        slv_req[0].b_ready = 1'b1;
        settle();
        chk("ew_idle_w", 128'(ccu_req.w_valid), 128'(0));
        chk("ew_idle_busy", 128'(busy), 128'(0));
        tick();
        chk("ew_no_grant", 128'(busy), 128'(0));
        slv_req[0].aw_valid = 1'b1;
        slv_req[0].aw.addr  = 32'hC0;
        tick();
        ccu_resp.w_ready  = 1'b1;
        ccu_resp.ar_ready = 1'b1;
        settle();
        chk("ew_gidx", 128'(gidx), 128'(0));
        chk("ew_w_valid", 128'(ccu_req.w_valid), 128'(1));
        chk("ew_w_data", 128'(ccu_req.w.data), 128'(32'h1234));
        chk("ew_ar_masked", 128'(ccu_req.ar_valid), 128'(0));
        chk("ew_aw_valid", 128'(ccu_req.aw_valid), 128'(1));
        chk("ew_w_ready", 128'(slv_resp[0].w_ready), 128'(1));
        tick();
        slv_req[0].w_valid = 1'b0;
        ccu_resp.w_ready   = 1'b0;
        ccu_resp.aw_ready  = 1'b1;
        settle();
        chk("ew_wait_aw_busy", 128'(busy), 128'(1));
        chk("ew_wait_ar_masked", 128'(ccu_req.ar_valid), 128'(0));
        tick();
        slv_req[0].aw_valid = 1'b0;
        ccu_resp = '0;
        ccu_resp.b_valid = 1'b1;
        settle();
        chk("ew_resp_ar_masked", 128'(ccu_req.ar_valid), 128'(0));
        chk("ew_b_valid", 128'(slv_resp[0].b_valid), 128'(1));
        tick();
        ccu_resp = '0;
        clear_reqs();
        settle();
        chk("ew_release", 128'(busy), 128'(0));

        // ---------------- reset during RESP of a port-2 read (rr_ptr=1)
        slv_req[2].ar_valid = 1'b1;
        slv_req[2].r_ready  = 1'b1;
        tick();
        chk("mr_gidx", 128'(gidx), 128'(2));
        ccu_resp.ar_ready = 1'b1;
        tick();
        ccu_resp.ar_ready = 1'b0;
        ccu_resp.r_valid  = 1'b1;
        ccu_resp.r.last   = 1'b0;
        settle();
        chk("mr_resp_busy", 128'(busy), 128'(1));
        rst_n = 1'b0;
        settle();
        chk("mr_rst_busy", 128'(busy), 128'(0));
        chk("mr_rst_gidx", 128'(gidx), 128'(0));
        chk("mr_rst_ccu_req", 128'(ccu_req), 128'(0));
        chk("mr_rst_slv2", 128'(slv_resp[2]), 128'(0));
        tick();
        chk("mr_rst_hold", 128'(busy), 128'(0));
        rst_n    = 1'b1;
        ccu_resp = '0;
        settle();
        chk("mr_post_idle", 128'(busy), 128'(0));
        tick();
        chk("mr_regrant_gidx", 128'(gidx), 128'(2));
        chk("mr_regrant_busy", 128'(busy), 128'(1));
        chk("mr_regrant_ar", 128'(ccu_req.ar_valid), 128'(1));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/ccu_txn_arbiter.md
Name: ccu_txn_arbiter

Overview:
- Transaction-level arbiter that shares a single CCU FSM between NoSlvPorts ACE initiating masters.
- Sits between the master-side ACE ports and the CCU request input/response output.
- Grants one master at a time, round-robin, and locks the grant until that master's read or write transaction fully completes.
- Ensures the CCU sees exactly one outstanding transaction and responses return only to the owner.

Parameters:
- NoSlvPorts, 4, number of initiating masters; must be >= 2.
- IdxWidth, $clog2(NoSlvPorts), width of the grant index (derived; do not override).
- slv_req_t, logic, ACE request struct (aw/w/ar channels plus b_ready/r_ready); same type the CCU consumes.
- slv_resp_t, logic, ACE response struct (aw_ready/w_ready/ar_ready, b/r channels).

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  asynchronous active-low reset.
- slv_req_i  input  NoSlvPorts x slv_req_t  requests from initiating masters.
- slv_resp_o  output  NoSlvPorts x slv_resp_t  responses to initiating masters.
- ccu_req_o  output  slv_req_t  request into the CCU FSM.
- ccu_resp_i  input  slv_resp_t  response from the CCU FSM.
- busy_o  output  1  high while a grant is held (ADDR or RESP).
- grant_idx_o  output  IdxWidth  index of the current/last granted port.

Behaviour:
- Reset (async, rst_ni=0):
  - state=IDLE, rr_ptr=0, grant_idx=0, is_read=0.
  - ccu_req_o='0, all slv_resp_o='0, busy_o=0, grant_idx_o=0.
- Port i requests when slv_req_i[i].ar_valid | slv_req_i[i].aw_valid.
- FSM states: IDLE, ADDR, RESP.
- IDLE:
  - ccu_req_o='0 and all slv_resp_o='0. No ready is exposed to any master, even if the CCU asserts ar_ready/aw_ready.
  - If any port requests, pick the first requesting index at or after rr_ptr (wrapping modulo NoSlvPorts).
  - Register grant_idx and is_read = that port's ar_valid. AR has priority over AW when both are valid.
  - Go to ADDR next cycle. Latency from request to CCU visibility is 1 cycle.
- ADDR:
  - ccu_req_o = slv_req_i[grant_idx], except the unused address channel is masked: aw_valid=0 if is_read, ar_valid=0 if write.
  - slv_resp_o[grant_idx] = ccu_resp_i with the masked channel's ready forced to 0. Other ports get '0.
  - Leave ADDR on the address handshake: ar_valid&ar_ready if read, aw_valid&aw_ready if write. Then go to RESP.
- RESP:
  - Forward as in ADDR, but force both ar_valid and aw_valid to 0 toward the CCU. Force both ar_ready and aw_ready to 0 toward the master, so the owner cannot issue a second transaction.
  - W, B and R channels pass through unchanged.
  - Release condition: read completes on r_valid & r_ready & r.last; write completes on b_valid & b_ready.
  - On release: go to IDLE, rr_ptr = grant_idx+1 (wrapping NoSlvPorts-1 -> 0).
- The W channel passes through in both ADDR and RESP for write grants. This allows W to precede the AW handshake, as the CCU requires in DECODE_W.
- busy_o=1 in ADDR and RESP. grant_idx_o holds its value in IDLE.
- Simultaneous release and new requests: the new grant is decided in the following IDLE cycle, giving one mandatory bubble cycle.
- A requester that drops valid while ungranted is ignored; no state is kept per port.
- A granted master must keep valid asserted until handshake (AXI rule); the arbiter does not check this.
- Reset asserted mid-transaction: immediate return to the reset values above. No completion is generated for the aborted owner.
- No timeout; a hung CCU holds the grant indefinitely.

Test Plan:
- Single read: port 2 asserts ar_valid at cycle 0 (addr 0x40) -> grant_idx_o=2 and ccu_req_o.ar_valid=1 at cycle 1; ar handshake moves to RESP; r with last=1 and r_ready -> IDLE next cycle, rr_ptr=3, busy_o=0.
- Round-robin fairness: ports 0,1,3 request continuously with reads -> grant order 0,1,3,0,1,3, with exactly one IDLE bubble between grants.
- Same-port AR+AW: port 1 asserts ar_valid and aw_valid together -> read granted first with aw_ready=0 to port 1; after read completion the write is granted on a later arbitration round.
- Write with early W: port 0 asserts w_valid before aw_valid -> w forwarded in ADDR; aw handshake, then b_valid&b_ready -> release; ar_valid to CCU held at 0 throughout.
- Isolation: while port 3 is in RESP, port 0 asserts ar_valid -> slv_resp_o[0]='0 until release, and ccu_req_o.ar_valid stays 0.
- Reset mid-RESP: rst_ni low for 1 cycle during a read -> all outputs '0, state IDLE, rr_ptr=0; after reset, a pending port 2 request is granted at the next edge.
